// File: rtl/ppc_seven_segment_driver_pkg.sv
// Shared display constants for the ping-pong counter display stage.
//   SEG_*        active-low segment patterns {g,f,e,d,c,b,a}
//   SEG_UP/DOWN  direction arrow glyphs
//   SEG_BLANK    all segments off
//   AN_OFF       all anodes off
//   CODE_UP/DOWN decoder input codes that select the arrow glyphs
package ppc_seven_segment_driver_pkg;

   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_UP    = 7'b1011100;
   localparam logic [6:0] SEG_DOWN  = 7'b1100011;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [3:0] AN_OFF    = 4'b1111;

   // Codes 10 and 11 never occur as decimal digits, so the arrows share the
   // digit path and a single decoder serves all four positions.
   localparam logic [3:0] CODE_UP   = 4'hA;
   localparam logic [3:0] CODE_DOWN = 4'hB;

   function automatic logic [3:0] ones_digit(input logic [3:0] v);
      return (v >= 4'd10) ? v - 4'd10 : v;
   endfunction

   function automatic logic [3:0] tens_digit(input logic [3:0] v);
      return {3'b000, (v >= 4'd10)};
   endfunction

endpackage

// File: rtl/ppc_seven_segment_driver_seven_seg_decoder.sv
// Combinational digit decoder: 4-bit code -> active-low segment pattern.
//   digit  in  4  0..9 decimal, CODE_UP / CODE_DOWN arrows, other codes blank
//   seg    out 7  {g,f,e,d,c,b,a}, active-low
module seven_seg_decoder
   import ppc_seven_segment_driver_pkg::*;
(
   input  logic [3:0] digit,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      case (digit)
         4'd0:      seg = SEG_0;
         4'd1:      seg = SEG_1;
         4'd2:      seg = SEG_2;
         4'd3:      seg = SEG_3;
         4'd4:      seg = SEG_4;
         4'd5:      seg = SEG_5;
         4'd6:      seg = SEG_6;
         4'd7:      seg = SEG_7;
         4'd8:      seg = SEG_8;
         4'd9:      seg = SEG_9;
         CODE_UP:   seg = SEG_UP;
         CODE_DOWN: seg = SEG_DOWN;
         default:   seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/ppc_seven_segment_driver.sv
// Four-digit common-anode seven-segment scanner for the ping-pong counter.
// Digits 3..2 show a direction arrow, digits 1..0 show value as 00..15.
//   clk        in  1  system clock
//   rst_n      in  1  asynchronous active-low reset
//   enable     in  1  0 blanks all digits; scanning keeps running
//   value      in  4  counter value
//   direction  in  1  1 = up, 0 = down
//   an         out 4  anodes, active-low, an[0] rightmost
//   seg        out 7  segments {g,f,e,d,c,b,a}, active-low
//   dp         out 1  decimal point, always off
module ppc_seven_segment_driver
   import ppc_seven_segment_driver_pkg::*;
#(
   parameter int DIV_BITS = 17
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       enable,
   input  logic [3:0] value,
   input  logic       direction,
   output logic [3:0] an,
   output logic [6:0] seg,
   output logic       dp
);

   logic [DIV_BITS-1:0] div_cnt;
   logic                tick;
   logic [1:0]          scan_idx;
   logic [3:0]          val_q;
   logic                dir_q;
   logic [3:0]          digit;
   logic [6:0]          seg_dec;
   logic [3:0]          an_sel;

   assign tick = &div_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt  <= '0;
         scan_idx <= 2'd0;
         val_q    <= 4'd0;
         dir_q    <= 1'b1;
      end else begin
         div_cnt <= div_cnt + DIV_BITS'(1);
         if (tick) begin
            scan_idx <= scan_idx + 2'd1;
            // Snapshot only at the frame boundary so a frame is self-consistent.
            if (scan_idx == 2'd3) begin
               val_q <= value;
               dir_q <= direction;
            end
         end
      end
   end

   always_comb begin
      digit = CODE_UP;
      case (scan_idx)
         2'd0:    digit = ones_digit(val_q);
         2'd1:    digit = tens_digit(val_q);
         default: digit = dir_q ? CODE_UP : CODE_DOWN;
      endcase
   end

   seven_seg_decoder u_dec (
      .digit (digit),
      .seg   (seg_dec)
   );

   assign an_sel = ~(4'b0001 << scan_idx);

   // Anodes and segments come from one register stage driven by a single
   // scan_idx, so at most one anode can ever be low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         an  <= AN_OFF;
         seg <= SEG_BLANK;
      end else if (enable) begin
         an  <= an_sel;
         seg <= seg_dec;
      end else begin
         an  <= AN_OFF;
         seg <= SEG_BLANK;
      end
   end

   assign dp = 1'b1;

endmodule

// File: tb/tb_ppc_seven_segment_driver.sv
module tb_ppc_seven_segment_driver;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       enable;
   logic [3:0] value;
   logic       direction;
   logic [3:0] an;
   logic [6:0] seg;
   logic       dp;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   bit chk_onehot = 1'b0;

   localparam logic [6:0] S_UP   = 7'b1011100;
   localparam logic [6:0] S_DOWN = 7'b1100011;
   localparam logic [6:0] S_DIG [10] = '{7'b1000000, 7'b1111001, 7'b0100100,
      7'b0110000, 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000};

   ppc_seven_segment_driver #(.DIV_BITS(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .enable    (enable),
      .value     (value),
      .direction (direction),
      .an        (an),
      .seg       (seg),
      .dp        (dp)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b (cyc %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic chk_digit(input string tag, input logic [3:0] e_an, input logic [6:0] e_seg);
      chk({tag, ".an"}, {3'b000, an}, {3'b000, e_an});
      chk({tag, ".seg"}, seg, e_seg);
   endtask

   // One clock: active edge, then sample at the following falling edge.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (chk_onehot) chk("onehot_an", 7'($countones(~an)), 7'd1);
   endtask

   task automatic run_to(input int n);
      while (cyc < n) step();
   endtask

   initial begin
      rst_n = 1'b0;
      enable = 1'b1;
      value = 4'd0;
      direction = 1'b1;

      // 1. reset
      @(negedge clk);
      chk_digit("rst0", 4'b1111, 7'b1111111);
      chk("rst0.dp", {6'd0, dp}, 7'd1);
      @(negedge clk);
      chk_digit("rst1", 4'b1111, 7'b1111111);
      rst_n = 1'b1;
      cyc = 0;
      run_to(1);
      chk_digit("post_rst_idx0", 4'b1110, S_DIG[0]);
      run_to(4);
      chk_digit("tick1_idx0", 4'b1110, S_DIG[0]);
      run_to(5);
      chk_digit("tick1_idx1", 4'b1101, S_DIG[0]);

      // 2. value 13, up, over two frames (snapshot on edges 16 and 32)
      value = 4'd13;
      direction = 1'b1;
      run_to(9);
      chk_digit("pre_snap_idx2", 4'b1011, S_UP);
      run_to(17);
      chk_digit("v13_idx0", 4'b1110, S_DIG[3]);
      run_to(21);
      chk_digit("v13_idx1", 4'b1101, S_DIG[1]);
      run_to(25);
      chk_digit("v13_idx2", 4'b1011, S_UP);
      run_to(29);
      chk_digit("v13_idx3", 4'b0111, S_UP);
      chk("v13.dp", {6'd0, dp}, 7'd1);
      run_to(33);
      chk_digit("v13_f2_idx0", 4'b1110, S_DIG[3]);

      // 3. change inputs while idx1 is on display
      run_to(37);
      value = 4'd4;
      direction = 1'b0;
      run_to(38);
      chk_digit("hold_idx1", 4'b1101, S_DIG[1]);
      run_to(41);
      chk_digit("hold_idx2", 4'b1011, S_UP);
      run_to(45);
      chk_digit("hold_idx3", 4'b0111, S_UP);
      run_to(49);
      chk_digit("v4_idx0", 4'b1110, S_DIG[4]);
      run_to(53);
      chk_digit("v4_idx1", 4'b1101, S_DIG[0]);
      run_to(57);
      chk_digit("v4_idx2", 4'b1011, S_DOWN);

      // 4. blank during idx2, re-enable during idx0
      enable = 1'b0;
      run_to(58);
      chk("blank_an", {3'b000, an}, 7'b0001111);
      run_to(62);
      chk("blank_an_idx3", {3'b000, an}, 7'b0001111);
      run_to(65);
      chk("blank_an_idx0", {3'b000, an}, 7'b0001111);
      enable = 1'b1;
      run_to(66);
      chk_digit("reen_idx0", 4'b1110, S_DIG[4]);
      run_to(69);
      chk_digit("reen_idx1", 4'b1101, S_DIG[0]);
      run_to(73);
      chk_digit("reen_idx2", 4'b1011, S_DOWN);

      // 5. asynchronous reset pulse in the middle of idx3
      run_to(78);
      chk_digit("pre_arst_idx3", 4'b0111, S_DOWN);
      value = 4'd7;
      #2;
      rst_n = 1'b0;
      #1;
      chk_digit("arst_async", 4'b1111, 7'b1111111);
      @(negedge clk);
      chk_digit("arst_held", 4'b1111, 7'b1111111);
      rst_n = 1'b1;
      cyc = 0;
      run_to(1);
      chk_digit("restart_idx0", 4'b1110, S_DIG[0]);
      run_to(5);
      chk_digit("restart_idx1", 4'b1101, S_DIG[0]);
      run_to(9);
      chk_digit("restart_idx2", 4'b1011, S_UP);
      run_to(13);
      chk_digit("restart_idx3", 4'b0111, S_UP);

      // 6. sweep 0..15, one value per frame
      chk_onehot = 1'b1;
      for (int v = 0; v < 16; v++) begin
         logic [3:0] vv;
         int base;
         vv = 4'(v);
         base = 16 * (v + 1);
         run_to(base - 2);
         value = vv;
         direction = vv[0];
         run_to(base + 1);
         chk_digit($sformatf("sweep%0d_ones", v), 4'b1110, S_DIG[v % 10]);
         run_to(base + 5);
         chk_digit($sformatf("sweep%0d_tens", v), 4'b1101, S_DIG[v / 10]);
         run_to(base + 9);
         chk_digit($sformatf("sweep%0d_arrow2", v), 4'b1011, vv[0] ? S_UP : S_DOWN);
         run_to(base + 13);
         chk_digit($sformatf("sweep%0d_arrow3", v), 4'b0111, vv[0] ? S_UP : S_DOWN);
      end
      chk_onehot = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
